// File: rtl/simon_round_ctrl.sv
// Simon Says round controller: fetches a random target set, runs a per-round
// countdown shown on a thermometer LED bar, then scores the buttons and tracks rounds and lives.
module simon_round_ctrl #(
    parameter int IN_W           = 16,
    parameter int DIGITS         = 3,
    parameter int ROUNDS         = 10,
    parameter int LIVES          = 3,
    parameter int TICKS_PER_STEP = 1000,
    parameter int TIMER_STEPS    = 16,
    parameter int SPEEDUP        = 1,
    parameter int MIN_STEPS      = 4,
    localparam int IW = (IN_W > 1) ? $clog2(IN_W) : 1,
    localparam int RW = $clog2(ROUNDS + 1),
    localparam int LW = $clog2(LIVES + 1),
    localparam int SW = $clog2(TIMER_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ack,
    input  logic                     start,
    input  logic [IN_W-1:0]          btn,
    output logic                     rnd_req,
    input  logic                     rnd_valid,
    input  logic [DIGITS*IW:0]       rnd_data,
    output logic [DIGITS*IW-1:0]     target,
    output logic                     says,
    output logic [2:0]               state,
    output logic [RW-1:0]            round,
    output logic [LW-1:0]            lives,
    output logic [TIMER_STEPS-1:0]   led_bar,
    output logic                     blue,
    output logic                     green,
    output logic                     red
);

    localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_FETCH = 3'd2,
        ST_GAME  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_FAIL  = 3'd5,
        ST_WIN   = 3'd6,
        ST_OVER  = 3'd7
    } state_t;

    state_t                 state_r, state_nx_s;
    logic [RW-1:0]          round_r, round_nx_s;
    logic [LW-1:0]          lives_r, lives_nx_s;
    logic [SW-1:0]          timer_r, timer_nx_s;
    logic [PW-1:0]          presc_r, presc_nx_s;
    logic [DIGITS*IW-1:0]   target_r, target_nx_s;
    logic                   says_r, says_nx_s;
    logic                   ack_d_r, start_d_r;
    logic                   ack_e_s, start_e_s;
    logic                   pass_s;
    logic [TIMER_STEPS-1:0] led_bar_s;

    // Timer length for a round; computed in signed arithmetic so late rounds clamp to the floor.
    function automatic logic [SW-1:0] steps_f(input logic [RW-1:0] r);
        int t;
        t = TIMER_STEPS - (int'(r) * SPEEDUP);
        if (t < MIN_STEPS) begin
            t = MIN_STEPS;
        end else begin
            t = t;
        end
        return SW'(t);
    endfunction

    // OR of one-hot digits; repeated digits land on the same bit.
    function automatic logic [IN_W-1:0] mask_f(input logic [DIGITS*IW-1:0] t);
        logic [IN_W-1:0] m;
        m = {IN_W{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            for (int i = 0; i < IN_W; i++) begin
                m[i] = m[i] | (t[k*IW +: IW] == IW'(i));
            end
        end
        return m;
    endfunction

    assign ack_e_s   = ack & ~ack_d_r;
    assign start_e_s = start & ~start_d_r;
    assign pass_s    = says_r ? (btn == mask_f(target_r)) : (btn == {IN_W{1'b0}});

    // Next-state and next-register computation for the round FSM.
    always_comb begin
        state_nx_s  = state_r;
        round_nx_s  = round_r;
        lives_nx_s  = lives_r;
        timer_nx_s  = timer_r;
        presc_nx_s  = presc_r;
        target_nx_s = target_r;
        says_nx_s   = says_r;
        case (state_r)
            ST_IDLE: begin
                if (ack_e_s) begin
                    round_nx_s = {RW{1'b0}};
                    lives_nx_s = LW'(LIVES);
                    state_nx_s = ST_READY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READY: begin
                if (start_e_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_READY;
                end
            end
            ST_FETCH: begin
                if (rnd_valid) begin
                    target_nx_s = rnd_data[DIGITS*IW-1:0];
                    says_nx_s   = rnd_data[DIGITS*IW];
                    timer_nx_s  = steps_f(round_r);
                    presc_nx_s  = {PW{1'b0}};
                    state_nx_s  = ST_GAME;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_GAME: begin
                if (presc_r == PW'(TICKS_PER_STEP - 1)) begin
                    presc_nx_s = {PW{1'b0}};
                    timer_nx_s = (timer_r != {SW{1'b0}}) ? (timer_r - 1'b1) : {SW{1'b0}};
                    state_nx_s = (timer_r <= SW'(1)) ? ST_EVAL : ST_GAME;
                end else begin
                    presc_nx_s = presc_r + 1'b1;
                end
            end
            ST_EVAL: begin
                if (pass_s) begin
                    round_nx_s = (round_r < RW'(ROUNDS)) ? (round_r + 1'b1) : round_r;
                    state_nx_s = (round_r >= RW'(ROUNDS - 1)) ? ST_WIN : ST_READY;
                end else begin
                    lives_nx_s = (lives_r != {LW{1'b0}}) ? (lives_r - 1'b1) : {LW{1'b0}};
                    state_nx_s = (lives_r <= LW'(1)) ? ST_OVER : ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (ack_e_s) begin
                    state_nx_s = ST_READY;
                end else begin
                    state_nx_s = ST_FAIL;
                end
            end
            ST_WIN, ST_OVER: begin
                if (ack_e_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            round_r   <= {RW{1'b0}};
            lives_r   <= LW'(LIVES);
            timer_r   <= {SW{1'b0}};
            presc_r   <= {PW{1'b0}};
            target_r  <= {(DIGITS*IW){1'b0}};
            says_r    <= 1'b0;
            ack_d_r   <= 1'b0;
            start_d_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            round_r   <= round_nx_s;
            lives_r   <= lives_nx_s;
            timer_r   <= timer_nx_s;
            presc_r   <= presc_nx_s;
            target_r  <= target_nx_s;
            says_r    <= says_nx_s;
            ack_d_r   <= ack;
            start_d_r <= start;
        end
    end

    // Thermometer decode of the remaining steps.
    always_comb begin
        led_bar_s = {TIMER_STEPS{1'b0}};
        for (int i = 0; i < TIMER_STEPS; i++) begin
            led_bar_s[i] = (i < int'(timer_r));
        end
    end

    assign led_bar = led_bar_s;
    assign state   = state_r;
    assign round   = round_r;
    assign lives   = lives_r;
    assign target  = target_r;
    assign says    = says_r;
    assign rnd_req = (state_r == ST_FETCH);
    assign blue    = (state_r == ST_GAME) & says_r;
    assign green   = ((state_r == ST_EVAL) & pass_s) | (state_r == ST_WIN);
    assign red     = ((state_r == ST_EVAL) & ~pass_s) | (state_r == ST_OVER);

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: vector table of scored rounds, random rounds
// against a round/lives model, and hand sequences for reset and edge-detect corners.
module tb_simon_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack, start, rnd_valid;
    logic [15:0] btn;
    logic [12:0] rnd_data;
    logic        rnd_req, says, blue, green, red;
    logic [11:0] target;
    logic [2:0]  state;
    logic [1:0]  round, lives;
    logic [3:0]  led_bar;

    int checks = 0;
    int errors = 0;
    int m_round = 0;
    int m_lives = 2;

    simon_round_ctrl #(
        .IN_W(16), .DIGITS(3), .ROUNDS(3), .LIVES(2), .TICKS_PER_STEP(2),
        .TIMER_STEPS(4), .SPEEDUP(1), .MIN_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .ack(ack), .start(start), .btn(btn),
        .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .target(target), .says(says), .state(state), .round(round), .lives(lives),
        .led_bar(led_bar), .blue(blue), .green(green), .red(red)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        says;
        logic [3:0]  d2, d1, d0;
        logic [15:0] btn;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_ack;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    // Plays one round from READY; expectations come from the model's round/lives.
    task automatic play_round(input logic s, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic [15:0] b, input logic exp_pass);
        int steps;
        int n;
        int exp_st;
        steps = 4 - m_round;
        if (steps < 2) steps = 2;
        check("ready", state, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fetch", state, 2);
        check("rnd_req", rnd_req, 1);
        rnd_data  = {s, d2, d1, d0};
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        check("game", state, 3);
        check("target", target, {d2, d1, d0});
        check("says", says, s);
        check("blue", blue, s);
        check("rnd_req_off", rnd_req, 0);
        btn = b;
        n = 0;
        while (state == 3'd3 && n < 64) begin
            check("led_bar", led_bar, (1 << (steps - n / 2)) - 1);
            tick();
            n++;
        end
        check("game_len", n, steps * 2);
        check("eval", state, 4);
        check("eval_green", green, exp_pass);
        check("eval_red", red, !exp_pass);
        if (exp_pass) begin
            if (m_round < 3) m_round++;
            exp_st = (m_round == 3) ? 6 : 1;
        end else begin
            if (m_lives > 0) m_lives--;
            exp_st = (m_lives == 0) ? 7 : 5;
        end
        tick();
        btn = 16'h0000;
        check("next_state", state, exp_st);
        check("round", round, m_round);
        check("lives", lives, m_lives);
        check("green_after", green, exp_st == 6);
        check("red_after", red, exp_st == 7);
    endtask

    // Returns the game to READY from FAIL, WIN or OVER.
    task automatic recover;
        if (state == 3'd5) begin
            pulse_ack();
            check("fail_to_ready", state, 1);
            check("round_kept", round, m_round);
        end else if (state == 3'd6 || state == 3'd7) begin
            pulse_ack();
            check("end_to_idle", state, 0);
            pulse_ack();
            m_round = 0;
            m_lives = 2;
            check("idle_to_ready", state, 1);
            check("reload_round", round, 0);
            check("reload_lives", lives, 2);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd3, 4'd1, 4'd0, 16'h000B, 1'b1};
        vecs[1] = '{1'b0, 4'd5, 4'd6, 4'd7, 16'h0000, 1'b1};
        vecs[2] = '{1'b1, 4'd2, 4'd2, 4'd2, 16'h0004, 1'b1};
        vecs[3] = '{1'b0, 4'd9, 4'd9, 4'd9, 16'h0001, 1'b0};
        vecs[4] = '{1'b1, 4'd15, 4'd0, 4'd7, 16'h8081, 1'b1};
        vecs[5] = '{1'b1, 4'd15, 4'd0, 4'd7, 16'h8080, 1'b0};
        vecs[6] = '{1'b0, 4'd1, 4'd2, 4'd3, 16'h000E, 1'b0};
        vecs[7] = '{1'b1, 4'd4, 4'd4, 4'd5, 16'h0030, 1'b1};

        rst = 1'b1; ack = 1'b0; start = 1'b0; rnd_valid = 1'b0;
        btn = 16'h0000; rnd_data = 13'h0000;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_round", round, 0);
        check("rst_lives", lives, 2);
        check("rst_led", led_bar, 0);
        check("rst_req", rnd_req, 0);
        check("rst_target", target, 0);
        check("rst_says", says, 0);
        check("rst_leds", {blue, green, red}, 0);
        rst = 1'b0;
        tick();

        // Start held high: edge in IDLE ignored, and no fresh edge once in READY.
        start = 1'b1;
        tick();
        check("start_idle", state, 0);
        pulse_ack();
        check("ack_ready", state, 1);
        check("ack_round", round, 0);
        check("ack_lives", lives, 2);
        tick();
        tick();
        check("start_held", state, 1);
        start = 1'b0;
        tick();

        // rnd_valid outside FETCH is ignored.
        rnd_data  = 13'h1FFF;
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        check("valid_ready", state, 1);
        check("valid_target", target, 0);

        for (int i = 0; i < 8; i++) begin
            play_round(vecs[i].says, vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].btn, vecs[i].exp_pass);
            recover();
        end

        for (int i = 0; i < 24; i++) begin
            logic        s;
            logic [3:0]  d2, d1, d0;
            logic [15:0] mask, b;
            s  = 1'($urandom_range(0, 1));
            d2 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            mask = s ? ((16'h0001 << d2) | (16'h0001 << d1) | (16'h0001 << d0)) : 16'h0000;
            b = ($urandom_range(0, 1) == 0) ? mask : 16'($urandom_range(0, 65535));
            play_round(s, d2, d1, d0, b, b == mask);
            recover();
        end

        // Asynchronous reset in FETCH and in GAME.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pre_rst_fetch", rnd_req, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_fetch_req", rnd_req, 0);
        check("rst_fetch_state", state, 0);
        rst = 1'b0;
        tick();
        pulse_ack();
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd_data  = {1'b1, 4'd1, 4'd2, 4'd3};
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_game", state, 3);
        #1 rst = 1'b1;
        #1;
        check("rst_game_state", state, 0);
        check("rst_game_led", led_bar, 0);
        check("rst_game_req", rnd_req, 0);
        check("rst_game_lives", lives, 2);
        check("rst_game_blue", blue, 0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
